// File: rtl/arith_pkg.sv
// Shared arithmetic constants and the serial FSM state encoding.
// Imported by the bit-serial datapath blocks.
package arith_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, bout = borrow.
// Used as the one per-bit slice of the serial subtractor.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor slice plus borrow flop.
// Result and borrow are registered on the last bit and held until the next.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic             bor;
  logic             d;
  logic             bout;
  logic             last;
  logic             accept;

  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (bor),
    .d    (d),
    .bout (bout)
  );

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = start &&
                  (state == ST_IDLE || state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // DONE accepts a new start just like IDLE, for back-to-back ops
  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE: state_nx = start ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_nx = last ? ST_DONE : ST_BUSY;
      ST_DONE: state_nx = start ? ST_BUSY : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_BUSY: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      work       <= '0;
      cnt        <= '0;
      bor        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      work <= '0;
      cnt  <= '0;
      bor  <= 1'b0;
    end else if (state == ST_BUSY) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      work <= {d, work[WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
      bor  <= bout;
      if (last) begin
        diff       <= {d, work[WIDTH-1:1]};
        borrow_out <= bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Expected results come from plain integer subtraction.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] held_d = '0;
  logic         held_b = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag,
                          input logic eb_busy,
                          input logic eb_done,
                          input logic [W-1:0] ed,
                          input logic eb);
    chk({tag, ".busy"}, 32'(busy), 32'(eb_busy));
    chk({tag, ".done"}, 32'(done), 32'(eb_done));
    chk({tag, ".diff"}, 32'(diff), 32'(ed));
    chk({tag, ".bor"}, 32'(borrow_out), 32'(eb));
  endtask

  // called at a negedge; returns at the negedge of BUSY cycle 1
  task automatic launch(input logic [W-1:0] x,
                        input logic [W-1:0] y);
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic busy_phase(input string tag, input bit inject);
    for (int i = 0; i < W; i++) begin
      chk_outs(tag, 1'b1, 1'b0, held_d, held_b);
      if (inject && i == 3) begin
        start = 1'b1;
        a = 8'h55;
        b = 8'h22;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic done_phase(input string tag,
                            input logic [W-1:0] x,
                            input logic [W-1:0] y);
    held_d = x - y;
    held_b = (x < y);
    chk_outs({tag, ".done"}, 1'b0, 1'b1, held_d, held_b);
  endtask

  task automatic full_op(input string tag,
                         input logic [W-1:0] x,
                         input logic [W-1:0] y);
    launch(x, y);
    busy_phase(tag, 1'b0);
    done_phase(tag, x, y);
    @(negedge clk);
    chk_outs({tag, ".hold"}, 1'b0, 1'b0, held_d, held_b);
  endtask

  initial begin
    logic [W-1:0] rx, ry;

    for (int i = 0; i < 3; i++) begin
      start = ~start;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      chk_outs("reset", 1'b0, 1'b0, 8'h00, 1'b0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_outs("post_reset", 1'b0, 1'b0, 8'h00, 1'b0);

    full_op("basic", 8'h05, 8'h03);
    full_op("borrow", 8'h03, 8'h05);
    full_op("zero", 8'h00, 8'h00);
    full_op("ff_01", 8'hFF, 8'h01);
    full_op("80_ff", 8'h80, 8'hFF);

    launch(8'h10, 8'h01);
    busy_phase("ignore", 1'b1);
    done_phase("ignore", 8'h10, 8'h01);
    chk("ignore.val", 32'(diff), 32'h0F);
    launch(8'h55, 8'h22);
    busy_phase("b2b", 1'b0);
    done_phase("b2b", 8'h55, 8'h22);
    chk("b2b.val", 32'(diff), 32'h33);
    @(negedge clk);

    launch(8'h40, 8'h01);
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outs("abort.async", 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    held_d = '0;
    held_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_outs("abort.quiet", 1'b0, 1'b0, 8'h00, 1'b0);
    end
    full_op("after_abort", 8'h09, 8'h04);
    chk("after_abort.val", 32'(diff), 32'h05);

    for (int n = 0; n < 20; n++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      full_op("rand", rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout");
  end

endmodule
